// File: rtl/i2s_record_receiver_if.sv
// -----------------------------------------------------------------------------
// i2s_record_receiver_if
// Frame handshake between the I2S record receiver and the AXI-side consumer.
//   frame_data  : {left, right} stereo frame, left word in the MSBs
//   frame_valid : frame_data holds an unconsumed frame
//   frame_ready : consumer accepts the frame while frame_valid is high
// Modports:
//   master : frame producer (the receiver)
//   slave  : frame consumer
// -----------------------------------------------------------------------------
interface i2s_record_receiver_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic [2*SAMPLE_WIDTH-1:0] frame_data;
    logic                      frame_valid;
    logic                      frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/i2s_record_receiver.sv
// -----------------------------------------------------------------------------
// i2s_record_receiver
// Oversamples the codec record pins (bclk, reclrc, recdat) in the axi_clk
// domain, locks to the LR clock and assembles 2*SAMPLE_WIDTH-bit stereo frames
// {left, right}, presented on a valid/ready handshake with sticky error flags.
//
// Ports:
//   axi_clk_i      block clock, at least 8x the bclk frequency
//   axi_aresetn_i  asynchronous active-low reset
//   ac_bclk_i      codec serial bit clock (asynchronous)
//   ac_reclrc_i    codec record LR clock, 0 = left, 1 = right
//   ac_recdat_i    codec record serial data, MSB first
//   rec_en_i       capture enable
//   status_clr_i   single-cycle clear of overrun_o / sync_error_o
//   locked_o       high while the receiver tracks LEFT/RIGHT slots
//   overrun_o      sticky: a completed frame was dropped (output full)
//   sync_error_o   sticky: LR transition before a full word was captured
//   frame_if       frame handshake (master side)
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | capture disabled, partial word discarded
//   ST_SYNC  | enabled, waiting for an lrc 1->0 edge (start of a left slot)
//   ST_LEFT  | collecting the left word
//   ST_RIGHT | collecting the right word, frame published on its last bit
// -----------------------------------------------------------------------------
module i2s_record_receiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                         axi_clk_i,
    input  logic                         axi_aresetn_i,
    input  logic                         ac_bclk_i,
    input  logic                         ac_reclrc_i,
    input  logic                         ac_recdat_i,
    input  logic                         rec_en_i,
    input  logic                         status_clr_i,
    output logic                         locked_o,
    output logic                         overrun_o,
    output logic                         sync_error_o,
    i2s_record_receiver_if.master        frame_if
);

    localparam int                 CNT_W    = $clog2(SAMPLE_WIDTH + 1);
    localparam int                 FRAME_W  = 2 * SAMPLE_WIDTH;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. All three pins go through the same depth so
    // lrc and dat stay aligned with the bclk edge that qualifies them.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrc_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   bclk_dly_q;
    logic                   lrc_prev_q;

    logic bclk_s;
    logic lrc_s;
    logic dat_s;
    logic bclk_rise;
    logic lrc_edge;

    always_ff @(posedge axi_clk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            bclk_sync_q <= '0;
            lrc_sync_q  <= '0;
            dat_sync_q  <= '0;
            bclk_dly_q  <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], ac_bclk_i};
            lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0],  ac_reclrc_i};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0],  ac_recdat_i};
            bclk_dly_q  <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lrc_s     = lrc_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_dly_q;
    assign lrc_edge  = bclk_rise & (lrc_s != lrc_prev_q);

    // lrc history is tracked even while idle so that the first edge seen
    // after enabling is a genuine transition, not a reset artefact.
    always_ff @(posedge axi_clk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            lrc_prev_q <= 1'b0;
        end else if (bclk_rise) begin
            lrc_prev_q <= lrc_s;
        end
    end

    // ------------------------------------------------------------------
    // Word shifter and bit counter
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] word_q, word_d;
    logic [SAMPLE_WIDTH-1:0] word_full;
    logic                    cap_done;

    // Word as it will look once the current bit is shifted in; used to
    // latch/publish on the same cycle the last bit arrives.
    assign word_full = {word_q[SAMPLE_WIDTH-2:0], dat_s};

    // The data bit on the lrc edge belongs to the previous slot, so the
    // edge only resets the counter and never captures.
    assign cap_done = bclk_rise && !lrc_edge && (bit_cnt_q == CNT_LAST);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            word_d    = '0;
        end else if (lrc_edge) begin
            bit_cnt_d = '0;
        end else if (bclk_rise && (bit_cnt_q < CNT_FULL)) begin
            word_d    = word_full;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            bit_cnt_q <= '0;
            word_q    <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
        end
    end

    // ------------------------------------------------------------------
    // Slot-tracking FSM
    // ------------------------------------------------------------------
    logic left_load;
    logic publish;
    logic sync_err_set;

    always_ff @(posedge axi_clk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        left_load    = 1'b0;
        publish      = 1'b0;
        sync_err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rec_en_i) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (lrc_edge && !lrc_s) begin
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (cap_done) begin
                    left_load = 1'b1;
                end
                if (lrc_edge) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        state_d = ST_RIGHT;
                    end else begin
                        sync_err_set = 1'b1;
                        state_d      = ST_SYNC;
                    end
                end
            end
            ST_RIGHT: begin
                if (cap_done) begin
                    publish = 1'b1;
                end
                if (lrc_edge) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        state_d = ST_LEFT;
                    end else begin
                        sync_err_set = 1'b1;
                        state_d      = ST_SYNC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Disabling overrides everything, including a frame completing in
        // the same cycle.
        if (!rec_en_i) begin
            state_d      = ST_IDLE;
            left_load    = 1'b0;
            publish      = 1'b0;
            sync_err_set = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Left holding register, output frame, sticky flags
    // ------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic [FRAME_W-1:0]      frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sync_err_q, sync_err_d;
    logic                    locked_q;

    always_comb begin
        left_d        = left_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        sync_err_d    = sync_err_q;

        if (left_load) begin
            left_d = word_full;
        end

        if (frame_valid_q && frame_if.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        if (status_clr_i) begin
            overrun_d  = 1'b0;
            sync_err_d = 1'b0;
        end

        if (publish) begin
            // An accept in the same cycle frees the slot for the new frame.
            if (!frame_valid_q || frame_if.frame_ready) begin
                frame_data_d  = {left_q, word_full};
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (sync_err_set) begin
            sync_err_d = 1'b1;
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            left_q        <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            left_q        <= left_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= (state_q == ST_LEFT) || (state_q == ST_RIGHT);
        end
    end

    assign frame_if.frame_data  = frame_data_q;
    assign frame_if.frame_valid = frame_valid_q;
    assign locked_o             = locked_q;
    assign overrun_o            = overrun_q;
    assign sync_error_o         = sync_err_q;

endmodule

// File: tb/tb_i2s_record_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_record_receiver
// Drives an I2S record stream (bclk = axi_clk/16, 32-bit slots) into the
// receiver. Expected frames are queued as each stereo pair is sent; a
// monitor pops and compares whenever the DUT hands over a frame.
// -----------------------------------------------------------------------------
module tb_i2s_record_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic bclk;
    logic lrc;
    logic dat;
    logic rec_en;
    logic status_clr;
    logic locked;
    logic overrun;
    logic sync_err;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];
    logic [47:0] mon_exp;

    i2s_record_receiver_if #(.SAMPLE_WIDTH(24)) fif ();

    i2s_record_receiver #(
        .SAMPLE_WIDTH (24),
        .SYNC_STAGES  (2)
    ) dut (
        .axi_clk_i     (clk),
        .axi_aresetn_i (rst_n),
        .ac_bclk_i     (bclk),
        .ac_reclrc_i   (lrc),
        .ac_recdat_i   (dat),
        .rec_en_i      (rec_en),
        .status_clr_i  (status_clr),
        .locked_o      (locked),
        .overrun_o     (overrun),
        .sync_error_o  (sync_err),
        .frame_if      (fif)
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handover is valid&ready seen before the edge.
    always @(negedge clk) begin
        if (rst_n && fif.frame_valid && fif.frame_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got %h expected none", fif.frame_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (fif.frame_data !== mon_exp) begin
                    errors++;
                    $display("FAIL frame_data: got %h expected %h", fif.frame_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One slot of nb bclk periods. Bit 0 carries the previous slot's tail,
    // bits 1..24 carry w MSB first, the rest are padding.
    // en_at  : bit index at which rec_en rises (-1 = never)
    // acc    : in a right slot, pulse frame_ready around the last-bit capture
    // rst_at : bit index at which reset is pulsed (-1 = never)
    task automatic slot(input logic l, input logic [23:0] w, input int nb,
                        input int en_at, input bit acc, input int rst_at);
        for (int i = 0; i < nb; i++) begin
            bclk = 1'b0;
            lrc  = l;
            if (i >= 1 && i <= 24) dat = w[24-i];
            else                   dat = 1'b0;
            if (i == en_at) rec_en = 1'b1;
            if (rst_at >= 0 && i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_frame_data",  fif.frame_data, 48'h0);
                chk("rst_frame_valid", {47'h0, fif.frame_valid}, 48'h0);
                chk("rst_locked",      {47'h0, locked}, 48'h0);
                chk("rst_overrun",     {47'h0, overrun}, 48'h0);
                chk("rst_sync_error",  {47'h0, sync_err}, 48'h0);
            end
            if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
            repeat (8) tick();
            bclk = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                tick();
                // bclk_rise for this bit is seen during the cycle before the
                // third edge after the pin rises; ready is held for that cycle only.
                if (acc && l && i == 24) begin
                    if (k == 2) fif.frame_ready = 1'b1;
                    if (k == 3) fif.frame_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic pair(input logic [23:0] lw, input logic [23:0] rw, input bit acc);
        slot(1'b0, lw, 32, -1, 1'b0, -1);
        slot(1'b1, rw, 32, -1, acc, -1);
    endtask

    initial begin
        rst_n           = 1'b0;
        bclk            = 1'b0;
        lrc             = 1'b0;
        dat             = 1'b0;
        rec_en          = 1'b0;
        status_clr      = 1'b0;
        fif.frame_ready = 1'b1;

        repeat (3) tick();
        chk("reset_frame_data",  fif.frame_data, 48'h0);
        chk("reset_frame_valid", {47'h0, fif.frame_valid}, 48'h0);
        chk("reset_locked",      {47'h0, locked}, 48'h0);
        chk("reset_overrun",     {47'h0, overrun}, 48'h0);
        chk("reset_sync_error",  {47'h0, sync_err}, 48'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic capture
        rec_en = 1'b1;
        slot(1'b1, 24'h000000, 32, -1, 1'b0, -1);
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(48'hABCDEF_123456);
            pair(24'hABCDEF, 24'h123456, 1'b0);
        end
        chk("basic_locked",     {47'h0, locked}, 48'h1);
        chk("basic_overrun",    {47'h0, overrun}, 48'h0);
        chk("basic_sync_error", {47'h0, sync_err}, 48'h0);

        // Disable, then enable in the middle of a left slot
        rec_en = 1'b0;
        repeat (4) tick();
        chk("disabled_locked", {47'h0, locked}, 48'h0);
        slot(1'b0, 24'h111111, 32, 10, 1'b0, -1);
        slot(1'b1, 24'h222222, 32, -1, 1'b0, -1);
        exp_q.push_back(48'h0F0F0F_F0F0F0);
        pair(24'h0F0F0F, 24'hF0F0F0, 1'b0);
        chk("midframe_locked", {47'h0, locked}, 48'h1);

        // Backpressure: A held, B dropped
        fif.frame_ready = 1'b0;
        exp_q.push_back(48'hA5A5A5_5A5A5A);
        pair(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        pair(24'hC3C3C3, 24'h3C3C3C, 1'b0);
        chk("bp_valid",   {47'h0, fif.frame_valid}, 48'h1);
        chk("bp_held",    fif.frame_data, 48'hA5A5A5_5A5A5A);
        chk("bp_overrun", {47'h0, overrun}, 48'h1);
        fif.frame_ready = 1'b1;
        tick();
        tick();
        chk("bp_drained", {47'h0, fif.frame_valid}, 48'h0);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        tick();
        chk("bp_overrun_clr", {47'h0, overrun}, 48'h0);

        // Short (16-bit) left slot
        slot(1'b0, 24'h765432, 16, -1, 1'b0, -1);
        slot(1'b1, 24'h111111, 32, -1, 1'b0, -1);
        chk("short_sync_error", {47'h0, sync_err}, 48'h1);
        chk("short_locked",     {47'h0, locked}, 48'h0);
        chk("short_no_frame",   {47'h0, fif.frame_valid}, 48'h0);
        exp_q.push_back(48'h89ABCD_456789);
        pair(24'h89ABCD, 24'h456789, 1'b0);
        chk("resync_locked", {47'h0, locked}, 48'h1);
        chk("sticky_sync",   {47'h0, sync_err}, 48'h1);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        tick();
        chk("sync_clr", {47'h0, sync_err}, 48'h0);

        // Accept and publish in the same cycle
        fif.frame_ready = 1'b0;
        exp_q.push_back(48'h135790_246801);
        pair(24'h135790, 24'h246801, 1'b0);
        exp_q.push_back(48'hFEDCBA_987654);
        pair(24'hFEDCBA, 24'h987654, 1'b1);
        chk("simul_valid",   {47'h0, fif.frame_valid}, 48'h1);
        chk("simul_data",    fif.frame_data, 48'hFEDCBA_987654);
        chk("simul_overrun", {47'h0, overrun}, 48'h0);
        fif.frame_ready = 1'b1;
        tick();
        tick();

        // Reset during a right slot while a frame is held
        fif.frame_ready = 1'b0;
        pair(24'h777777, 24'h888888, 1'b0);
        chk("pre_rst_valid",  {47'h0, fif.frame_valid}, 48'h1);
        chk("pre_rst_locked", {47'h0, locked}, 48'h1);
        slot(1'b0, 24'h999999, 32, -1, 1'b0, -1);
        slot(1'b1, 24'hAAAAAA, 32, -1, 1'b0, 10);
        chk("post_rst_locked", {47'h0, locked}, 48'h0);
        fif.frame_ready = 1'b1;
        exp_q.push_back(48'h031415_926535);
        pair(24'h031415, 24'h926535, 1'b0);
        chk("post_rst_relock", {47'h0, locked}, 48'h1);

        repeat (20) tick();
        chk("scoreboard_empty", 48'(exp_q.size()), 48'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
